// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide unit: one shift-add or shift-subtract step per RUN cycle,
// with every add/subtract done by an external shared ALU.
`ifndef ALU_OP_AND
`define ALU_OP_AND  4'b0000
`endif
`ifndef ALU_OP_ADDU
`define ALU_OP_ADDU 4'b0010
`endif
`ifndef ALU_OP_SUBU
`define ALU_OP_SUBU 4'b0110
`endif

module muldiv_seq #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] hi,
    output logic [WORD_SIZE-1:0] lo,
    output logic [3:0]           alu_opcode,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_result
);
    localparam int CW = $clog2(WORD_SIZE + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [CW-1:0]        count_reg;
    logic                 op_reg;
    logic [WORD_SIZE-1:0] opnd_reg;     // multiplicand for MULTU, divisor for DIVU
    logic [WORD_SIZE-1:0] hi_reg, lo_reg;
    logic [WORD_SIZE-1:0] hi_next, lo_next;
    logic [WORD_SIZE-1:0] div_shift;
    logic                 carry;
    logic                 taken;
    logic                 accept;

    assign accept    = start && (state_reg != RUN);
    assign div_shift = {hi_reg[WORD_SIZE-2:0], lo_reg[WORD_SIZE-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        alu_opcode = `ALU_OP_AND;
        alu_a      = '0;
        alu_b      = '0;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        carry      = 1'b0;
        taken      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                if (count_reg == CW'(1)) state_next = DONE;
                if (op_reg) begin
                    alu_opcode = `ALU_OP_SUBU;
                    alu_a      = div_shift;
                    alu_b      = opnd_reg;
                    // hi MSB set means the shifted partial remainder overflowed the word, so it always exceeds the divisor
                    taken      = hi_reg[WORD_SIZE-1] || (div_shift >= opnd_reg);
                    hi_next    = taken ? alu_result : div_shift;
                    lo_next    = {lo_reg[WORD_SIZE-2:0], taken};
                end else begin
                    alu_opcode = `ALU_OP_ADDU;
                    alu_a      = hi_reg;
                    alu_b      = opnd_reg;
                    carry      = (alu_result < hi_reg);
                    if (lo_reg[0]) begin
                        hi_next = {carry, alu_result[WORD_SIZE-1:1]};
                        lo_next = {alu_result[0], lo_reg[WORD_SIZE-1:1]};
                    end else begin
                        hi_next = {1'b0, hi_reg[WORD_SIZE-1:1]};
                        lo_next = {hi_reg[0], lo_reg[WORD_SIZE-1:1]};
                    end
                end
            end
            DONE: begin
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            op_reg    <= 1'b0;
            opnd_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else if (accept) begin
            count_reg <= CW'(WORD_SIZE);
            op_reg    <= op;
            opnd_reg  <= op ? b : a;
            hi_reg    <= '0;
            lo_reg    <= op ? a : b;
        end else if (state_reg == RUN) begin
            count_reg <= count_reg - CW'(1);
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule
